// File: rtl/video_pkg.sv
// Shared video timing types for the mode-lock controller and related
// sync/scaler logic: mode codes, lock FSM states, per-frame timing record.
package video_pkg;

    // Width of every timing field carried in vtiming_t.
    localparam int VT_W = 16;

    typedef enum logic [1:0] {
        MODE_UNKNOWN  = 2'd0,
        MODE_PENTAGON = 2'd1,
        MODE_SPEC48   = 2'd2,
        MODE_SPEC128  = 2'd3
    } mode_e;

    // Encoding 3 is deliberately left unused.
    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } lock_state_e;

    typedef struct packed {
        logic [VT_W-1:0] line_cnt;
        logic [VT_W-1:0] line_len;
        mode_e           mode;
        logic            tv;
        logic            vga;
    } vtiming_t;

    // Reasons a held lock was abandoned.
    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISMATCH = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
    localparam logic [1:0] CAUSE_FORCE    = 2'd3;

    // A frame with zero lines or zero-length lines is a broken measurement.
    function automatic logic frame_is_valid(input vtiming_t f);
        return (f.line_cnt != '0) && (f.line_len != '0);
    endfunction

endpackage

// File: rtl/video_mode_lock_frame_match.sv
// frame_match: combinational comparison of one measured frame against a
// reference timing. Line count and mode must be equal; line length may
// differ by up to LEN_TOL clocks. Broken frames never match.
module frame_match
    import video_pkg::*;
#(
    parameter int LEN_TOL = 4
) (
    input  vtiming_t meas,
    input  vtiming_t cand,
    output logic     valid,
    output logic     match
);

    localparam logic [VT_W:0] TOL = (VT_W+1)'(LEN_TOL);

    logic [VT_W:0] len_diff;

    // Unsigned magnitude of the length difference, one bit wider than the fields.
    always_comb begin
        if (meas.line_len >= cand.line_len) begin
            len_diff = {1'b0, meas.line_len} - {1'b0, cand.line_len};
        end else begin
            len_diff = {1'b0, cand.line_len} - {1'b0, meas.line_len};
        end
    end

    // Validity gates the match so a zero-length frame cannot slip inside tolerance.
    always_comb begin
        valid = frame_is_valid(meas);
        match = valid
              && (meas.line_cnt == cand.line_cnt)
              && (meas.mode == cand.mode)
              && (len_diff <= TOL);
    end

endmodule

// File: rtl/video_mode_lock.sv
// video_mode_lock: decides when the measured video timing is stable,
// holds it against short glitches and publishes it with a one-cycle
// config-update pulse. W must not exceed video_pkg::VT_W.
// Optional macro VIDEO_MODE_LOCK_STATS_EN adds lock-loss statistics ports.
module video_mode_lock
    import video_pkg::*;
#(
    parameter int LOCK_FRAMES   = 4,
    parameter int UNLOCK_FRAMES = 3,
    parameter int LEN_TOL       = 4,
    parameter int TIMEOUT       = 2000000,
    parameter int W             = 16
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         meas_rdy_i,
    input  logic [W-1:0] meas_line_cnt_i,
    input  logic [W-1:0] meas_line_len_i,
    input  logic [1:0]   meas_mode_i,
    input  logic         meas_tv_i,
    input  logic         meas_vga_i,
    input  logic         force_relock_i,
    output logic         locked_o,
    output logic [1:0]   mode_o,
    output logic [W-1:0] line_cnt_o,
    output logic [W-1:0] line_len_o,
    output logic         tv_mode_o,
    output logic         vga_mode_o,
    output logic         cfg_upd_o,
    output logic [1:0]   state_o
`ifdef VIDEO_MODE_LOCK_STATS_EN
    ,
    output logic [7:0]   lock_loss_cnt_o,
    output logic [1:0]   last_loss_cause_o
`endif
);

    localparam int             TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);
    localparam logic [3:0]     LOCK_N   = 4'(LOCK_FRAMES);
    localparam logic [3:0]     UNLOCK_N = 4'(UNLOCK_FRAMES);

    lock_state_e       state_q, state_d;
    vtiming_t          meas;
    vtiming_t          cand_q, cand_d;
    vtiming_t          held_q, held_d;
    logic [3:0]        ok_q, ok_d;
    logic [3:0]        miss_q, miss_d;
    logic [TMR_W-1:0]  timer_q;
    logic              timeout;
    logic              frame_valid;
    logic              frame_ok;
    logic              load_lock;

    // Pack the raw measurement ports into a timing record.
    always_comb begin
        meas.line_cnt = VT_W'(meas_line_cnt_i);
        meas.line_len = VT_W'(meas_line_len_i);
        meas.mode     = mode_e'(meas_mode_i);
        meas.tv       = meas_tv_i;
        meas.vga      = meas_vga_i;
    end

    frame_match #(
        .LEN_TOL (LEN_TOL)
    ) u_match (
        .meas  (meas),
        .cand  (cand_q),
        .valid (frame_valid),
        .match (frame_ok)
    );

    // Sync-loss watchdog: counts idle cycles since the last strobe, saturating.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            timer_q <= '0;
        end else if (meas_rdy_i) begin
            timer_q <= '0;
        end else if (timer_q != TMR_MAX) begin
            timer_q <= timer_q + 1'b1;
        end
    end

    assign timeout = (timer_q == TMR_MAX);

    // Lock FSM next state: force beats a strobe, a strobe beats the watchdog.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        held_d    = held_q;
        ok_d      = ok_q;
        miss_d    = miss_q;
        load_lock = 1'b0;

        if (force_relock_i) begin
            state_d = ST_SEARCH;
            ok_d    = '0;
            miss_d  = '0;
        end else if (meas_rdy_i) begin
            case (state_q)
                ST_SEARCH: begin
                    if (frame_valid) begin
                        cand_d = meas;
                        ok_d   = 4'd1;
                        miss_d = '0;
                        if (LOCK_N <= 4'd1) begin
                            state_d   = ST_LOCKED;
                            load_lock = 1'b1;
                            held_d    = meas;
                        end else begin
                            state_d = ST_VERIFY;
                        end
                    end
                end
                ST_VERIFY: begin
                    if (frame_ok) begin
                        ok_d = ok_q + 4'd1;
                        if ((ok_q + 4'd1) >= LOCK_N) begin
                            state_d         = ST_LOCKED;
                            load_lock       = 1'b1;
                            miss_d          = '0;
                            held_d          = cand_q;
                            held_d.line_len = meas.line_len;
                        end
                    end else if (frame_valid) begin
                        cand_d = meas;
                        ok_d   = 4'd1;
                    end else begin
                        state_d = ST_SEARCH;
                        ok_d    = '0;
                    end
                end
                ST_LOCKED: begin
                    if (frame_ok) begin
                        miss_d = '0;
                    end else if ((miss_q + 4'd1) >= UNLOCK_N) begin
                        state_d = ST_SEARCH;
                        ok_d    = '0;
                        miss_d  = '0;
                    end else begin
                        miss_d = miss_q + 4'd1;
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                    ok_d    = '0;
                    miss_d  = '0;
                end
            endcase
        end else if (timeout) begin
            state_d = ST_SEARCH;
            ok_d    = '0;
            miss_d  = '0;
        end

        if (!(state_q inside {ST_SEARCH, ST_VERIFY, ST_LOCKED})) begin
            state_d   = ST_SEARCH;
            ok_d      = '0;
            miss_d    = '0;
            load_lock = 1'b0;
            held_d    = held_q;
        end
    end

    // State, candidate and published timing registers; timing holds after lock loss.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_SEARCH;
            cand_q    <= '0;
            held_q    <= '0;
            ok_q      <= '0;
            miss_q    <= '0;
            locked_o  <= 1'b0;
            cfg_upd_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            held_q    <= held_d;
            ok_q      <= ok_d;
            miss_q    <= miss_d;
            locked_o  <= (state_d == ST_LOCKED);
            cfg_upd_o <= load_lock;
        end
    end

    assign mode_o     = held_q.mode;
    assign line_cnt_o = W'(held_q.line_cnt);
    assign line_len_o = W'(held_q.line_len);
    assign tv_mode_o  = held_q.tv;
    assign vga_mode_o = held_q.vga;
    assign state_o    = state_q;

`ifdef VIDEO_MODE_LOCK_STATS_EN
    logic [1:0] loss_cause;

    // Classify why a held lock is being dropped this cycle.
    always_comb begin
        loss_cause = CAUSE_NONE;
        if ((state_q == ST_LOCKED) && (state_d == ST_SEARCH)) begin
            if (force_relock_i) begin
                loss_cause = CAUSE_FORCE;
            end else if (meas_rdy_i) begin
                loss_cause = CAUSE_MISMATCH;
            end else begin
                loss_cause = CAUSE_TIMEOUT;
            end
        end
    end

    // Saturating lock-loss counter plus the most recent loss reason.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lock_loss_cnt_o   <= '0;
            last_loss_cause_o <= CAUSE_NONE;
        end else if (loss_cause != CAUSE_NONE) begin
            if (lock_loss_cnt_o != 8'hFF) begin
                lock_loss_cnt_o <= lock_loss_cnt_o + 8'd1;
            end
            last_loss_cause_o <= loss_cause;
        end
    end
`endif

endmodule

// File: tb/tb_video_mode_lock.sv
// Directed testbench for video_mode_lock with hand-computed expectations.
// Stats ports are exercised when VIDEO_MODE_LOCK_STATS_EN is defined.
module tb_video_mode_lock;

    localparam int LOCK_FRAMES   = 4;
    localparam int UNLOCK_FRAMES = 3;
    localparam int LEN_TOL       = 4;
    localparam int TIMEOUT       = 40;
    localparam int W             = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          meas_rdy = 1'b0;
    logic [W-1:0]  meas_line_cnt = '0;
    logic [W-1:0]  meas_line_len = '0;
    logic [1:0]    meas_mode = '0;
    logic          meas_tv = 1'b0;
    logic          meas_vga = 1'b0;
    logic          force_relock = 1'b0;
    logic          locked;
    logic [1:0]    mode;
    logic [W-1:0]  line_cnt;
    logic [W-1:0]  line_len;
    logic          tv_mode;
    logic          vga_mode;
    logic          cfg_upd;
    logic [1:0]    state;
`ifdef VIDEO_MODE_LOCK_STATS_EN
    logic [7:0]    loss_cnt;
    logic [1:0]    loss_cause;
`endif

    int errors = 0;
    int checks = 0;

    video_mode_lock #(
        .LOCK_FRAMES   (LOCK_FRAMES),
        .UNLOCK_FRAMES (UNLOCK_FRAMES),
        .LEN_TOL       (LEN_TOL),
        .TIMEOUT       (TIMEOUT),
        .W             (W)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .meas_rdy_i      (meas_rdy),
        .meas_line_cnt_i (meas_line_cnt),
        .meas_line_len_i (meas_line_len),
        .meas_mode_i     (meas_mode),
        .meas_tv_i       (meas_tv),
        .meas_vga_i      (meas_vga),
        .force_relock_i  (force_relock),
        .locked_o        (locked),
        .mode_o          (mode),
        .line_cnt_o      (line_cnt),
        .line_len_o      (line_len),
        .tv_mode_o       (tv_mode),
        .vga_mode_o      (vga_mode),
        .cfg_upd_o       (cfg_upd),
        .state_o         (state)
`ifdef VIDEO_MODE_LOCK_STATS_EN
        ,
        .lock_loss_cnt_o   (loss_cnt),
        .last_loss_cause_o (loss_cause)
`endif
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // All tasks start and end just after a falling edge.
    task automatic do_reset();
        rst_n        = 1'b0;
        meas_rdy     = 1'b0;
        force_relock = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] cnt, input logic [W-1:0] len,
                        input logic [1:0] md, input logic tv, input logic vga);
        meas_line_cnt = cnt;
        meas_line_len = len;
        meas_mode     = md;
        meas_tv       = tv;
        meas_vga      = vga;
        meas_rdy      = 1'b1;
        @(negedge clk);
        meas_rdy = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (state !== 2'd0) begin
            errors++; $display("[TB] FAIL rst_state: got %0d expected 0", state);
        end
        repeat (LOCK_FRAMES) send(16'd300, 16'd1800, 2'd1, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({locked, cfg_upd, tv_mode, vga_mode, mode, state} !== 8'h00) begin
            errors++; $display("[TB] FAIL rst_async_flags: got %h expected 00",
                               {locked, cfg_upd, tv_mode, vga_mode, mode, state});
        end
        checks++;
        if ({line_cnt, line_len} !== 32'h0) begin
            errors++; $display("[TB] FAIL rst_async_timing: got %h expected 0", {line_cnt, line_len});
        end
`ifdef VIDEO_MODE_LOCK_STATS_EN
        checks++;
        if ({loss_cnt, loss_cause} !== 10'h0) begin
            errors++; $display("[TB] FAIL rst_stats: got %h expected 0", {loss_cnt, loss_cause});
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lock_acquire();
        do_reset();
        repeat (LOCK_FRAMES - 1) send(16'd312, 16'd1792, 2'd2, 1'b1, 1'b0);
        checks++;
        if ({locked, state} !== 3'b0_01) begin
            errors++; $display("[TB] FAIL acq_pre_lock: got locked=%0d state=%0d expected 0/1", locked, state);
        end
        send(16'd312, 16'd1792, 2'd2, 1'b1, 1'b0);
        checks++;
        if ({locked, cfg_upd, state} !== 4'b1_1_10) begin
            errors++; $display("[TB] FAIL acq_lock: got locked=%0d upd=%0d state=%0d expected 1/1/2",
                               locked, cfg_upd, state);
        end
        checks++;
        if (line_cnt !== 16'd312 || mode !== 2'd2 || line_len !== 16'd1792) begin
            errors++; $display("[TB] FAIL acq_timing: got cnt=%0d mode=%0d len=%0d expected 312/2/1792",
                               line_cnt, mode, line_len);
        end
        checks++;
        if ({tv_mode, vga_mode} !== 2'b10) begin
            errors++; $display("[TB] FAIL acq_flags: got tv=%0d vga=%0d expected 1/0", tv_mode, vga_mode);
        end
        idle(1);
        checks++;
        if ({locked, cfg_upd} !== 2'b10) begin
            errors++; $display("[TB] FAIL acq_pulse_width: got locked=%0d upd=%0d expected 1/0", locked, cfg_upd);
        end
    endtask

    task automatic test_tolerance();
        do_reset();
        repeat (LOCK_FRAMES - 1) send(16'd320, 16'd1792, 2'd2, 1'b0, 1'b0);
        send(16'd320, 16'd1794, 2'd2, 1'b0, 1'b0);
        checks++;
        if (locked !== 1'b1 || line_len !== 16'd1794) begin
            errors++; $display("[TB] FAIL tol_latest_len: got locked=%0d len=%0d expected 1/1794", locked, line_len);
        end
        send(16'd320, 16'd1795, 2'd2, 1'b0, 1'b0);
        send(16'd320, 16'd1789, 2'd2, 1'b0, 1'b0);
        send(16'd320, 16'd1796, 2'd2, 1'b0, 1'b0);
        send(16'd320, 16'd1788, 2'd2, 1'b0, 1'b0);
        checks++;
        if (locked !== 1'b1 || cfg_upd !== 1'b0 || line_len !== 16'd1794) begin
            errors++; $display("[TB] FAIL tol_within: got locked=%0d upd=%0d len=%0d expected 1/0/1794",
                               locked, cfg_upd, line_len);
        end
        send(16'd320, 16'd1797, 2'd2, 1'b0, 1'b0);
        send(16'd320, 16'd1797, 2'd2, 1'b0, 1'b0);
        checks++;
        if (locked !== 1'b1) begin
            errors++; $display("[TB] FAIL tol_two_miss: got locked=%0d expected 1", locked);
        end
        send(16'd320, 16'd1797, 2'd2, 1'b0, 1'b0);
        checks++;
        if (locked !== 1'b0 || state !== 2'd0) begin
            errors++; $display("[TB] FAIL tol_outside: got locked=%0d state=%0d expected 0/0", locked, state);
        end
    endtask

    task automatic test_unlock();
        do_reset();
        repeat (LOCK_FRAMES) send(16'd320, 16'd1792, 2'd1, 1'b0, 1'b0);
        send(16'd311, 16'd1792, 2'd1, 1'b0, 1'b0);
        send(16'd311, 16'd1792, 2'd1, 1'b0, 1'b0);
        send(16'd320, 16'd1792, 2'd1, 1'b0, 1'b0);
        send(16'd311, 16'd1792, 2'd1, 1'b0, 1'b0);
        send(16'd311, 16'd1792, 2'd1, 1'b0, 1'b0);
        checks++;
        if (locked !== 1'b1 || state !== 2'd2) begin
            errors++; $display("[TB] FAIL unl_miss_reset: got locked=%0d state=%0d expected 1/2", locked, state);
        end
        send(16'd311, 16'd1792, 2'd1, 1'b0, 1'b0);
        checks++;
        if (locked !== 1'b0 || state !== 2'd0 || cfg_upd !== 1'b0) begin
            errors++; $display("[TB] FAIL unl_drop: got locked=%0d state=%0d upd=%0d expected 0/0/0",
                               locked, state, cfg_upd);
        end
        checks++;
        if (line_cnt !== 16'd320 || mode !== 2'd1 || line_len !== 16'd1792) begin
            errors++; $display("[TB] FAIL unl_hold: got cnt=%0d mode=%0d len=%0d expected 320/1/1792",
                               line_cnt, mode, line_len);
        end
`ifdef VIDEO_MODE_LOCK_STATS_EN
        checks++;
        if (loss_cnt !== 8'd1 || loss_cause !== 2'd1) begin
            errors++; $display("[TB] FAIL unl_stats: got cnt=%0d cause=%0d expected 1/1", loss_cnt, loss_cause);
        end
`endif
    endtask

    task automatic test_timeout();
        do_reset();
        repeat (LOCK_FRAMES) send(16'd320, 16'd1792, 2'd2, 1'b0, 1'b0);
        idle(TIMEOUT);
        checks++;
        if (locked !== 1'b1 || state !== 2'd2) begin
            errors++; $display("[TB] FAIL tmo_before: got locked=%0d state=%0d expected 1/2", locked, state);
        end
        send(16'd320, 16'd1792, 2'd2, 1'b0, 1'b0);
        checks++;
        if (locked !== 1'b1 || state !== 2'd2) begin
            errors++; $display("[TB] FAIL tmo_strobe_on_expiry: got locked=%0d state=%0d expected 1/2",
                               locked, state);
        end
        idle(TIMEOUT);
        checks++;
        if (locked !== 1'b1) begin
            errors++; $display("[TB] FAIL tmo_timer_cleared: got locked=%0d expected 1", locked);
        end
        idle(1);
        checks++;
        if (locked !== 1'b0 || state !== 2'd0 || line_cnt !== 16'd320) begin
            errors++; $display("[TB] FAIL tmo_expired: got locked=%0d state=%0d cnt=%0d expected 0/0/320",
                               locked, state, line_cnt);
        end
`ifdef VIDEO_MODE_LOCK_STATS_EN
        checks++;
        if (loss_cnt !== 8'd1 || loss_cause !== 2'd2) begin
            errors++; $display("[TB] FAIL tmo_stats: got cnt=%0d cause=%0d expected 1/2", loss_cnt, loss_cause);
        end
`endif
    endtask

    task automatic test_verify_recapture();
        do_reset();
        send(16'd312, 16'd1792, 2'd2, 1'b0, 1'b0);
        send(16'd312, 16'd1792, 2'd2, 1'b0, 1'b0);
        send(16'd311, 16'd1792, 2'd3, 1'b0, 1'b1);
        send(16'd311, 16'd1792, 2'd3, 1'b0, 1'b1);
        send(16'd311, 16'd1792, 2'd3, 1'b0, 1'b1);
        checks++;
        if (locked !== 1'b0 || state !== 2'd1) begin
            errors++; $display("[TB] FAIL ver_recapture: got locked=%0d state=%0d expected 0/1", locked, state);
        end
        send(16'd311, 16'd1792, 2'd3, 1'b0, 1'b1);
        checks++;
        if (locked !== 1'b1 || cfg_upd !== 1'b1 || mode !== 2'd3 || line_cnt !== 16'd311 || vga_mode !== 1'b1) begin
            errors++; $display("[TB] FAIL ver_lock: got locked=%0d upd=%0d mode=%0d cnt=%0d vga=%0d expected 1/1/3/311/1",
                               locked, cfg_upd, mode, line_cnt, vga_mode);
        end
        do_reset();
        send(16'd312, 16'd1792, 2'd2, 1'b0, 1'b0);
        send(16'd0, 16'd1792, 2'd2, 1'b0, 1'b0);
        checks++;
        if (state !== 2'd0) begin
            errors++; $display("[TB] FAIL ver_invalid: got state=%0d expected 0", state);
        end
        send(16'd312, 16'd0, 2'd2, 1'b0, 1'b0);
        checks++;
        if (state !== 2'd0) begin
            errors++; $display("[TB] FAIL srch_invalid: got state=%0d expected 0", state);
        end
    endtask

    task automatic test_force();
        do_reset();
        repeat (LOCK_FRAMES) send(16'd312, 16'd1792, 2'd2, 1'b0, 1'b0);
        meas_line_cnt = 16'd312;
        meas_line_len = 16'd1792;
        meas_mode     = 2'd2;
        meas_rdy      = 1'b1;
        force_relock  = 1'b1;
        @(negedge clk);
        meas_rdy     = 1'b0;
        force_relock = 1'b0;
        checks++;
        if (locked !== 1'b0 || state !== 2'd0 || cfg_upd !== 1'b0 || line_cnt !== 16'd312) begin
            errors++; $display("[TB] FAIL frc_drop: got locked=%0d state=%0d upd=%0d cnt=%0d expected 0/0/0/312",
                               locked, state, cfg_upd, line_cnt);
        end
`ifdef VIDEO_MODE_LOCK_STATS_EN
        checks++;
        if (loss_cnt !== 8'd1 || loss_cause !== 2'd3) begin
            errors++; $display("[TB] FAIL frc_stats: got cnt=%0d cause=%0d expected 1/3", loss_cnt, loss_cause);
        end
`endif
        repeat (LOCK_FRAMES - 1) send(16'd312, 16'd1792, 2'd2, 1'b0, 1'b0);
        checks++;
        if (locked !== 1'b0 || state !== 2'd1) begin
            errors++; $display("[TB] FAIL frc_strobe_ignored: got locked=%0d state=%0d expected 0/1", locked, state);
        end
        send(16'd312, 16'd1792, 2'd2, 1'b0, 1'b0);
        checks++;
        if (locked !== 1'b1 || cfg_upd !== 1'b1) begin
            errors++; $display("[TB] FAIL frc_relock_pulse: got locked=%0d upd=%0d expected 1/1", locked, cfg_upd);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        @(negedge clk);
        test_reset();
        test_lock_acquire();
        test_tolerance();
        test_unlock();
        test_timeout();
        test_verify_recapture();
        test_force();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
